serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 133 +++++++++++++
 tb/tb_serial_subtractor.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first) with valid/ready.
// Optional signed-overflow output ovf enabled by defining SERIAL_SUB_OVF_EN.

module sub_1_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sub,
  output logic cout
);
  assign sub  = a ^ b ^ cin;
  assign cout = (~a & b) | (~(a ^ b) & cin);
endmodule

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [CW-1:0]    cnt;
  logic             borrow_ff;
  logic             sbit;
  logic             cout;
  logic             last;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb;
  logic b_msb;
`endif

  sub_1_bit u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (borrow_ff),
    .sub  (sbit),
    .cout (cout)
  );

  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath; result registers are only written during SHIFT,
  // so they stay frozen through DONE backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      cnt        <= '0;
      borrow_ff  <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr      <= a;
            b_sr      <= b;
            borrow_ff <= 1'b0;
            cnt       <= '0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb     <= a[WIDTH-1];
            b_msb     <= b[WIDTH-1];
`endif
          end
        end
        SHIFT: begin
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          diff      <= {sbit, diff[WIDTH-1:1]};
          borrow_ff <= cout;
          if (last) begin
            borrow_out <= cout;
`ifdef SERIAL_SUB_OVF_EN
            ovf <= (a_msb != b_msb) && (sbit != a_msb);
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8).
// Define SERIAL_SUB_OVF_EN to also exercise the ovf output.

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
    .ovf        (ovf),
`endif
    .borrow_out (borrow_out)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait for the result, check it, leave state at DONE
  // (out_ready low) or back in IDLE (out_ready high).
  task automatic do_op(input string tag, input logic [7:0] av,
                       input logic [7:0] bv, input logic [7:0] ed,
                       input logic eb, input logic eo, input logic rdy);
    int n;
    n = 0;
    while (!in_ready && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_in_ready"}, in_ready, 1'b1);
    out_ready = rdy;
    a = av;
    b = bv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_borrow"}, borrow_out, eb);
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, ovf, eo);
`else
    if (eo) $display("note: %s expects ovf with feature enabled", tag);
`endif
    if (rdy) begin
      tick();
      check({tag, "_ready_after"}, in_ready, 1'b1);
      check({tag, "_valid_after"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_borrow", borrow_out, 1'b0);

    do_op("op5a23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b1);
    do_op("op1020", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b1);
    do_op("op00ff", 8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    do_op("opa5a5", 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 1'b1);

    // Backpressure with fresh operands pending on the input side
    do_op("bp", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    a = 8'hFF;
    b = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_diff", diff, 8'h37);
      check("bp_borrow", borrow_out, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release", in_ready, 1'b1);
    do_op("opff01", 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b1);

    // Abort mid-SHIFT
    a = 8'h80;
    b = 8'h01;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_valid", out_valid, 1'b0);
    check("abort_diff", diff, 8'h00);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("abort_no_result", n, 0);
    do_op("op0904", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_SUB_OVF_EN
    do_op("ovf8001", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    do_op("ovf7fff", 8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
    do_op("ovf0503", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
